// File: rtl/tick_ctrl.sv
// tick_ctrl: debounced run/pause control that emits a one-cycle slow_clk enable every DIV cycles.
// Optional single-step button path is compiled only when TICK_CTRL_STEP_EN is defined.

module tick_ctrl_deb #(
  parameter int unsigned DEB = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);
  localparam logic [23:0] DEB_M1 = 24'(DEB - 1);

  logic        sync_a;
  logic        sync_b;
  logic        level;
  logic        level_q;
  logic [23:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a  <= 1'b0;
      sync_b  <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_a  <= btn;
      sync_b  <= sync_a;
      level_q <= level;
      // Level only moves after DEB consecutive cycles of disagreement.
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == DEB_M1) begin
        level <= sync_b;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 24'd1;
      end
    end
  end

  assign press = level & ~level_q;
endmodule

module tick_ctrl #(
  parameter int unsigned DIV = 50000000,
  parameter int unsigned DEB = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_run,
  input  logic btn_step,
  output logic slow_clk,
  output logic running
);
  typedef enum logic {PAUSED = 1'b0, RUNNING = 1'b1} state_t;

  localparam logic [31:0] DIV_M1 = DIV - 32'd1;

  state_t      state;
  logic [31:0] pre;
  logic        run_press;
  logic        step_press;

  tick_ctrl_deb #(.DEB(DEB)) u_run_deb (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_run),
    .press (run_press)
  );

`ifdef TICK_CTRL_STEP_EN
  tick_ctrl_deb #(.DEB(DEB)) u_step_deb (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_step),
    .press (step_press)
  );
`else
  logic unused_step;
  assign unused_step = btn_step;
  assign step_press  = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= PAUSED;
      running  <= 1'b0;
      pre      <= '0;
      slow_clk <= 1'b0;
    end else begin
      slow_clk <= 1'b0;
      case (state)
        PAUSED: begin
          pre <= '0;
          // A coincident run press wins and the step is discarded.
          if (run_press) begin
            state   <= RUNNING;
            running <= 1'b1;
          end else if (step_press) begin
            slow_clk <= ~slow_clk;
          end
        end
        RUNNING: begin
          // Pausing on the terminal count suppresses that tick.
          if (run_press) begin
            state   <= PAUSED;
            running <= 1'b0;
            pre     <= '0;
          end else if (pre == DIV_M1) begin
            pre      <= '0;
            slow_clk <= ~slow_clk;
          end else begin
            pre <= pre + 32'd1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tick_ctrl.sv
// Directed bench for tick_ctrl with DIV=4, DEB=3; step expectations follow TICK_CTRL_STEP_EN.
`timescale 1ns/1ps
module tb_tick_ctrl;
  localparam int DIV = 4;
  localparam int DEB = 3;
`ifdef TICK_CTRL_STEP_EN
  localparam int SP = 1;
`else
  localparam int SP = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_run = 1'b0;
  logic btn_step = 1'b0;
  logic slow_clk;
  logic running;

  tick_ctrl #(.DIV(DIV), .DEB(DEB)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_run  (btn_run),
    .btn_step (btn_step),
    .slow_clk (slow_clk),
    .running  (running)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic run;
    logic step;
    int   n;
    logic exp_running;
    int   exp_pulses;
  } vec_t;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   rise_cnt = 0;
  int   fall_cnt = 0;
  int   last_rise = 0;
  int   last_fall = 0;
  logic prev_slow = 1'b0;
  logic prev_run = 1'b0;
  int   pulses[$];
  int   r, r2, c0, rc0, p0, prevp;
  logic found;
  vec_t vecs[11];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and log what the outputs did.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    if (slow_clk) begin
      pulses.push_back(cyc);
      check("no_back_to_back", prev_slow, 0);
    end
    if (running && !prev_run) begin rise_cnt++; last_rise = cyc; end
    if (!running && prev_run) begin fall_cnt++; last_fall = cyc; end
    prev_slow = slow_clk;
    prev_run  = running;
  endtask

  function automatic int count_pulses(input int lo, input int hi);
    int n = 0;
    foreach (pulses[i]) if (pulses[i] > lo && pulses[i] <= hi) n++;
    return n;
  endfunction

  function automatic int first_pulse(input int lo);
    int f = -1;
    foreach (pulses[i]) if (f < 0 && pulses[i] > lo) f = pulses[i];
    return f;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 5,  1'b0, 0};
    vecs[1]  = '{1'b0, 1'b1, 8,  1'b0, SP};
    vecs[2]  = '{1'b0, 1'b0, 8,  1'b0, 0};
    vecs[3]  = '{1'b0, 1'b1, 8,  1'b0, SP};
    vecs[4]  = '{1'b0, 1'b0, 8,  1'b0, 0};
    vecs[5]  = '{1'b0, 1'b1, 8,  1'b0, SP};
    vecs[6]  = '{1'b0, 1'b0, 8,  1'b0, 0};
    vecs[7]  = '{1'b1, 1'b1, 8,  1'b1, 0};
    vecs[8]  = '{1'b0, 1'b0, 10, 1'b1, 3};
    vecs[9]  = '{1'b0, 1'b1, 8,  1'b1, 2};
    vecs[10] = '{1'b0, 1'b0, 8,  1'b1, 2};

    // Reset state
    repeat (3) cycle();
    check("reset_running", running, 0);
    check("reset_slow_clk", slow_clk, 0);
    reset = 1'b0;
    repeat (3) cycle();

    // Two-cycle glitch must be rejected
    btn_run = 1'b1;
    repeat (2) cycle();
    btn_run = 1'b0;
    repeat (12) cycle();
    check("glitch_running", running, 0);
    check("glitch_pulses", pulses.size(), 0);

    // Long press: one toggle, 2 sync + 3 debounce + 1 FSM cycles
    rc0 = rise_cnt;
    c0 = cyc;
    btn_run = 1'b1;
    repeat (10) cycle();
    btn_run = 1'b0;
    for (int i = 0; i < 20 && rise_cnt == rc0; i++) cycle();
    check("run_rises", rise_cnt - rc0, 1);
    check("run_latency", last_rise - c0, 6);
    r = last_rise;
    while (cyc < r + 40) cycle();
    check("held_running", running, 1);
    check("held_no_fall", fall_cnt, 0);

    // Tick rate over 40 running cycles
    check("tick_count", count_pulses(r, r + 40), 10);
    check("first_tick", first_pulse(r) - r, 4);
    prevp = -1;
    foreach (pulses[i]) begin
      if (pulses[i] > r && pulses[i] <= r + 40) begin
        if (prevp >= 0) check("tick_spacing", pulses[i] - prevp, 4);
        prevp = pulses[i];
      end
    end

    // Pause lands while prescaler is at 3: that tick is suppressed
    while (cyc < r + 42) cycle();
    btn_run = 1'b1;
    repeat (4) cycle();
    btn_run = 1'b0;
    while (cyc < r + 60) cycle();
    check("pause_last_tick", count_pulses(r + 40, r + 44), 1);
    check("pause_fall_cycle", last_fall - r, 48);
    check("pause_no_pulse", count_pulses(r + 44, r + 60), 0);
    check("pause_running", running, 0);

    // Resume: first tick DIV cycles after running rises
    rc0 = rise_cnt;
    btn_run = 1'b1;
    repeat (4) cycle();
    btn_run = 1'b0;
    for (int i = 0; i < 20 && rise_cnt == rc0; i++) cycle();
    check("resume_rise", rise_cnt - rc0, 1);
    r2 = last_rise;
    while (cyc < r2 + 8) cycle();
    check("resume_first", first_pulse(r2) - r2, 4);
    check("resume_count", count_pulses(r2, r2 + 8), 2);

    // Asynchronous reset while slow_clk is high
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (slow_clk) found = 1'b1;
    end
    check("reset_tick_seen", found, 1);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_slow_clk", slow_clk, 0);
    check("rst_mid_running", running, 0);
    repeat (2) cycle();
    reset = 1'b0;
    p0 = pulses.size();
    repeat (20) cycle();
    check("post_reset_pulses", pulses.size() - p0, 0);
    check("post_reset_running", running, 0);

    // Step presses, coincidence, and step while running
    foreach (vecs[i]) begin
      p0 = pulses.size();
      btn_run  = vecs[i].run;
      btn_step = vecs[i].step;
      repeat (vecs[i].n) cycle();
      check($sformatf("vec%0d_running", i), running, vecs[i].exp_running);
      check($sformatf("vec%0d_pulses", i), pulses.size() - p0, vecs[i].exp_pulses);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
